// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for the BST mini game.
// Issues a question per round, judges one Same/Diff key press against is_correct, shows the
// result for a fixed hold time and keeps score. Keys are raw, low-active and asynchronous.
// Optional feature: define GRC_DEBOUNCE_EN to add a per-key debounce filter after the
// synchroniser. Without it, every synchronised falling edge is a press.
module game_round_ctrl #(
  parameter int unsigned ROUNDS       = 8,
  parameter int unsigned TIMEOUT_CYC  = 250_000_000,
  parameter int unsigned RESULT_CYC   = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       q_valid,
  input  logic       is_correct,
  input  logic       key_same_n,
  input  logic       key_diff_n,
  output logic       new_q,
  output logic       win,
  output logic       lose,
  output logic       timed_out,
  output logic [3:0] score,
  output logic [3:0] round,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int unsigned MaxCyc = (TIMEOUT_CYC > RESULT_CYC) ? TIMEOUT_CYC : RESULT_CYC;
  localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [TimerW-1:0] ResultLast  = TimerW'(RESULT_CYC - 1);
  localparam logic [3:0]        RoundsLast  = 4'(ROUNDS);

  // Elaboration-time parameter sanity checks
  if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
    $error("ROUNDS must be in 1..15");
  end
  if (TIMEOUT_CYC < 1 || RESULT_CYC < 1 || DEBOUNCE_CYC < 1) begin : g_bad_cycles
    $error("cycle counts must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StIssue  = 3'd1,
    StWait   = 3'd2,
    StResult = 3'd3,
    StDone   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        score_q, score_d;
  logic [3:0]        round_q, round_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;
  logic              timed_out_q, timed_out_d;
  logic [TimerW-1:0] timer_q, timer_d;

  // Key path, bit 0 = same, bit 1 = diff; all levels are low-active
  logic [1:0] key_raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] key_lvl;
  logic [1:0] prev_q;
  logic [1:0] press;

  assign key_raw = {key_diff_n, key_same_n};

  // Two-flop synchroniser, plus the previous filtered level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      prev_q  <= key_lvl;
    end
  end

`ifdef GRC_DEBOUNCE_EN
  localparam int unsigned DebW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYC - 1);

  logic [1:0][DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]           deb_lvl_q, deb_lvl_d;

  // Debounce: a new level must persist DEBOUNCE_CYC consecutive cycles to be accepted
  always_comb begin
    deb_cnt_d = '0;
    deb_lvl_d = deb_lvl_q;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != deb_lvl_q[k]) begin
        if (deb_cnt_q[k] == DebLast) begin
          deb_lvl_d[k] = sync2_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + DebW'(1);
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
      deb_lvl_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      deb_lvl_q <= deb_lvl_d;
    end
  end

  assign key_lvl = deb_lvl_q;
`else
  assign key_lvl = sync2_q;
`endif

  // A press is a falling edge of the filtered low-active level
  assign press = prev_q & ~key_lvl;

  logic one_press;
  logic answer_ok;
  logic result_end;

  // Simultaneous presses cancel; presses only count while the question is valid
  assign one_press  = q_valid & (press[0] ^ press[1]);
  assign answer_ok  = press[0] ? is_correct : ~is_correct;
  assign result_end = (timer_q == ResultLast);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; enable low aborts to IDLE from anywhere
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (q_valid) state_d = StIssue;
      StIssue:  state_d = StWait;
      StWait: begin
        if (one_press || (q_valid && timer_q == TimeoutLast)) state_d = StResult;
      end
      StResult: begin
        if (result_end) state_d = (round_q == RoundsLast) ? StDone : StIssue;
      end
      StDone:   state_d = StDone;
      default:  state_d = StIdle;
    endcase
    if (!enable) state_d = StIdle;
  end

  // Round datapath next state: score, round, result flags and the shared timer
  always_comb begin
    score_d     = score_q;
    round_d     = round_q;
    win_d       = win_q;
    lose_d      = lose_q;
    timed_out_d = timed_out_q;
    timer_d     = timer_q;
    unique case (state_q)
      StIssue: begin
        round_d = round_q + 4'd1;
        timer_d = '0;
      end
      StWait: begin
        if (one_press) begin
          timer_d = '0;
          if (answer_ok) begin
            score_d = score_q + 4'd1;
            win_d   = 1'b1;
          end else begin
            lose_d  = 1'b1;
          end
        end else if (q_valid) begin
          if (timer_q == TimeoutLast) begin
            timer_d     = '0;
            lose_d      = 1'b1;
            timed_out_d = 1'b1;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
      end
      StResult: begin
        if (result_end) begin
          timer_d     = '0;
          win_d       = 1'b0;
          lose_d      = 1'b0;
          timed_out_d = 1'b0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: ;
    endcase
    if (!enable) begin
      score_d     = '0;
      round_d     = '0;
      win_d       = 1'b0;
      lose_d      = 1'b0;
      timed_out_d = 1'b0;
      timer_d     = '0;
    end
  end

  // Round datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q     <= '0;
      round_q     <= '0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      timed_out_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      score_q     <= score_d;
      round_q     <= round_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      timed_out_q <= timed_out_d;
      timer_q     <= timer_d;
    end
  end

  // FSM outputs decoded from the current state
  always_comb begin
    new_q     = (state_q == StIssue);
    game_over = (state_q == StDone);
    state     = state_q;
  end

  assign win       = win_q;
  assign lose      = lose_q;
  assign timed_out = timed_out_q;
  assign score     = score_q;
  assign round     = round_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: constant-table game, directed corner cases and a randomized run
// compared every cycle against a behavioural model of the round rules.
module tb_game_round_ctrl;

  localparam int NRounds  = 3;
  localparam int NTimeout = 20;
  localparam int NResult  = 4;
  localparam int NDeb     = 3;
`ifdef GRC_DEBOUNCE_EN
  localparam int KeyDly = 2 + NDeb;
`else
  localparam int KeyDly = 2;
`endif
  localparam int Lat   = KeyDly + 1;  // clock edges from raw key fall to FSM reaction
  localparam int HistN = KeyDly + 2;

  logic       clk = 1'b0;
  logic       rst_n, enable, q_valid, is_correct, key_same_n, key_diff_n;
  logic       new_q, win, lose, timed_out, game_over;
  logic [3:0] score, round;
  logic [2:0] state;
  logic [15:0] dut_vec;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_no   = 0;
  bit model_chk = 1'b1;

  game_round_ctrl #(
    .ROUNDS      (NRounds),
    .TIMEOUT_CYC (NTimeout),
    .RESULT_CYC  (NResult),
    .DEBOUNCE_CYC(NDeb)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .q_valid   (q_valid),
    .is_correct(is_correct),
    .key_same_n(key_same_n),
    .key_diff_n(key_diff_n),
    .new_q     (new_q),
    .win       (win),
    .lose      (lose),
    .timed_out (timed_out),
    .score     (score),
    .round     (round),
    .game_over (game_over),
    .state     (state)
  );

  always #5 clk = ~clk;

  assign dut_vec = {state, score, round, win, lose, timed_out, game_over, new_q};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  int m_state, m_score, m_round, m_waited, m_hold;
  bit m_win, m_lose, m_to;
  bit hist_s [HistN];
  bit hist_d [HistN];

  function automatic logic [15:0] pack(int st, int sc, int rd, bit w, bit l, bit t, bit go, bit nq);
    return {3'(st), 4'(sc), 4'(rd), w, l, t, go, nq};
  endfunction

  task automatic model_clear();
    m_state = 0; m_score = 0; m_round = 0; m_waited = 0; m_hold = 0;
    m_win = 0; m_lose = 0; m_to = 0;
  endtask

  // A press is seen KeyDly cycles after the raw (low-active) key goes from high to low
  task automatic model_step();
    bit ps, pd;
    for (int k = HistN - 1; k > 0; k--) begin
      hist_s[k] = hist_s[k-1];
      hist_d[k] = hist_d[k-1];
    end
    hist_s[0] = key_same_n;
    hist_d[0] = key_diff_n;
    ps = hist_s[KeyDly+1] && !hist_s[KeyDly];
    pd = hist_d[KeyDly+1] && !hist_d[KeyDly];
    if (!enable) begin
      model_clear();
    end else begin
      case (m_state)
        0: if (q_valid) m_state = 1;
        1: begin m_round++; m_waited = 0; m_state = 2; end
        2: if (q_valid) begin
          if (ps != pd) begin
            if ((ps && is_correct) || (pd && !is_correct)) begin m_score++; m_win = 1; end
            else m_lose = 1;
            m_state = 3; m_hold = 0;
          end else begin
            m_waited++;
            if (m_waited == NTimeout) begin m_lose = 1; m_to = 1; m_state = 3; m_hold = 0; end
          end
        end
        3: begin
          m_hold++;
          if (m_hold == NResult) begin
            m_win = 0; m_lose = 0; m_to = 0;
            m_state = (m_round == NRounds) ? 4 : 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc_no, got, exp);
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    cyc_no++;
    if (!rst_n) begin
      model_clear();
      for (int k = 0; k < HistN; k++) begin hist_s[k] = 0; hist_d[k] = 0; end
    end else begin
      model_step();
    end
    @(negedge clk);
    if (model_chk)
      check("model", 32'(dut_vec),
            32'(pack(m_state, m_score, m_round, m_win, m_lose, m_to, m_state == 4, m_state == 1)));
  endtask

  task automatic apply(bit en, bit qv, bit ic, bit sn, bit dn, int n);
    enable = en; q_valid = qv; is_correct = ic; key_same_n = sn; key_diff_n = dn;
    repeat (n) tick();
  endtask

  typedef struct {
    bit          en, qv, ic, sn, dn;
    int          cyc;
    logic [15:0] exp;
  } vec_t;

  function automatic vec_t mk(bit en, bit qv, bit ic, bit sn, bit dn, int cyc, logic [15:0] exp);
    vec_t v;
    v.en = en; v.qv = qv; v.ic = ic; v.sn = sn; v.dn = dn; v.cyc = cyc; v.exp = exp;
    return v;
  endfunction

  vec_t tbl [17];
  int   k_cnt;
  int   cool, low_left, qv_off;

  initial begin
    // Game 1: correct(same), correct(diff), timeout -> DONE with score 2, then abort
    tbl[0]  = mk(0, 1, 1, 1, 1, 2,       pack(0, 0, 0, 0, 0, 0, 0, 0));
    tbl[1]  = mk(1, 1, 1, 1, 1, 1,       pack(1, 0, 0, 0, 0, 0, 0, 1));
    tbl[2]  = mk(1, 1, 1, 1, 1, 1,       pack(2, 0, 1, 0, 0, 0, 0, 0));
    tbl[3]  = mk(1, 1, 1, 0, 1, Lat,     pack(3, 1, 1, 1, 0, 0, 0, 0));
    tbl[4]  = mk(1, 1, 1, 1, 1, 3,       pack(3, 1, 1, 1, 0, 0, 0, 0));
    tbl[5]  = mk(1, 1, 0, 1, 1, 1,       pack(1, 1, 1, 0, 0, 0, 0, 1));
    tbl[6]  = mk(1, 1, 0, 1, 1, 1,       pack(2, 1, 2, 0, 0, 0, 0, 0));
    tbl[7]  = mk(1, 1, 0, 1, 0, Lat,     pack(3, 2, 2, 1, 0, 0, 0, 0));
    tbl[8]  = mk(1, 1, 0, 1, 1, 4,       pack(1, 2, 2, 0, 0, 0, 0, 1));
    tbl[9]  = mk(1, 1, 0, 1, 1, 1,       pack(2, 2, 3, 0, 0, 0, 0, 0));
    tbl[10] = mk(1, 1, 0, 1, 1, 19,      pack(2, 2, 3, 0, 0, 0, 0, 0));
    tbl[11] = mk(1, 1, 0, 1, 1, 1,       pack(3, 2, 3, 0, 1, 1, 0, 0));
    tbl[12] = mk(1, 1, 0, 1, 1, 3,       pack(3, 2, 3, 0, 1, 1, 0, 0));
    tbl[13] = mk(1, 1, 0, 1, 1, 1,       pack(4, 2, 3, 0, 0, 0, 1, 0));
    tbl[14] = mk(1, 1, 1, 0, 1, Lat + 2, pack(4, 2, 3, 0, 0, 0, 1, 0));
    tbl[15] = mk(1, 1, 1, 1, 1, 3,       pack(4, 2, 3, 0, 0, 0, 1, 0));
    tbl[16] = mk(0, 1, 1, 1, 1, 1,       pack(0, 0, 0, 0, 0, 0, 0, 0));

    rst_n = 0; enable = 0; q_valid = 0; is_correct = 0; key_same_n = 1; key_diff_n = 1;
    model_clear();
    repeat (3) tick();
    rst_n = 1;

    // Asynchronous reset in the middle of WAIT
    apply(1, 1, 1, 1, 1, 5);
    check("pre_reset_wait", 32'(state), 32'd2);
    #2 rst_n = 0;
    #1 check("async_reset_outputs", 32'(dut_vec), 32'd0);
    tick();
    tick();
    rst_n = 1;

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].en, tbl[i].qv, tbl[i].ic, tbl[i].sn, tbl[i].dn, tbl[i].cyc);
      check($sformatf("table[%0d]", i), 32'(dut_vec), 32'(tbl[i].exp));
    end

    // Game 2, round 1: wrong answer via same key
    apply(1, 1, 0, 1, 1, 2);
    check("g2_wait", 32'(state), 32'd2);
    apply(1, 1, 0, 0, 1, Lat);
    check("wrong_same", 32'({state, score, win, lose, timed_out}), 32'({3'd3, 4'd0, 3'b010}));
    apply(1, 1, 0, 1, 1, 5);
    check("g2_round2", 32'({state, round}), 32'({3'd2, 4'd2}));

    // Round 2: both keys together are ignored and do not disturb the timer
    apply(1, 1, 1, 0, 0, Lat + 3);
    check("both_keys_stay", 32'({state, win, lose}), 32'({3'd2, 2'b00}));
    k_cnt = 0;
    while (state != 3'd3 && k_cnt < 40) begin apply(1, 1, 1, 1, 1, 1); k_cnt++; end
    check("both_timeout_at", 32'(k_cnt), 32'(NTimeout - (Lat + 3)));
    check("both_timed_out", 32'({lose, timed_out}), 32'b11);

    // Round 3: q_valid low for 10 cycles freezes the timer
    apply(1, 1, 1, 1, 1, 5);
    check("g2_round3", 32'({state, round}), 32'({3'd2, 4'd3}));
    apply(1, 0, 1, 1, 1, 10);
    check("qv_low_wait", 32'(state), 32'd2);
    k_cnt = 0;
    while (state != 3'd3 && k_cnt < 60) begin apply(1, 1, 1, 1, 1, 1); k_cnt++; end
    check("qv_timeout_at", 32'(k_cnt), 32'(NTimeout));
    check("qv_timed_out", 32'({lose, timed_out}), 32'b11);
    apply(1, 1, 1, 1, 1, 4);
    check("g2_done", 32'({game_over, score, round}), 32'({1'b1, 4'd0, 4'd3}));

`ifdef GRC_DEBOUNCE_EN
    // Debounce: short glitch ignored, long press counted once
    model_chk = 0;
    apply(0, 1, 1, 1, 1, 2);
    apply(1, 1, 1, 1, 1, 2);
    check("deb_wait", 32'(state), 32'd2);
    apply(1, 1, 1, 0, 1, 2);
    apply(1, 1, 1, 1, 1, 8);
    check("deb_glitch", 32'({state, score, win}), 32'({3'd2, 4'd0, 1'b0}));
    apply(1, 1, 1, 0, 1, 5);
    apply(1, 1, 1, 1, 1, 15);
    check("deb_one_press", 32'({state, score, round}), 32'({3'd2, 4'd1, 4'd2}));
    apply(0, 1, 1, 1, 1, HistN + 2);
    model_chk = 1;
`endif

    // Randomized run against the model
    apply(0, 1, 1, 1, 1, 2);
    cool = 0; low_left = 0; qv_off = 0;
    for (int c = 0; c < 2000; c++) begin
      if (low_left > 0) begin
        low_left--;
        if (low_left == 0) begin key_same_n = 1; key_diff_n = 1; cool = 0; end
      end else begin
        cool++;
        if (cool >= 8 && $urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 4))
            0, 1:    key_same_n = 0;
            2, 3:    key_diff_n = 0;
            default: begin key_same_n = 0; key_diff_n = 0; end
          endcase
          low_left = $urandom_range(6, 9);
        end
      end
      enable = ($urandom_range(0, 59) != 0);
      if (qv_off > 0) begin
        qv_off--;
        q_valid = 0;
      end else if ($urandom_range(0, 24) == 0) begin
        qv_off  = $urandom_range(0, 5);
        q_valid = 0;
      end else begin
        q_valid = 1;
      end
      is_correct = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
